video_raster_irq: RTL and testbench

//  Parametrised raster timing and interrupt generator: H/V counters, blank/sync windows, paper window, flash divider.

---
 rtl/video_raster_irq_if.sv | 28 ++
 rtl/video_raster_irq.sv | 230 +++++++++++++++++++++++
 tb/tb_video_raster_irq.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_raster_irq_if.sv
// ----------------------------------------------------------------------------
// video_raster_irq_if
//   CPU I/O bus used by the raster/interrupt block for line-compare writes,
//   interrupt acknowledge and status readback.
//
//   Signals
//     addr     CPU address (low byte selects the port, [9:8] the channel)
//     din      CPU write data
//     nIORQ    I/O request strobe, active-low
//     nWR      write strobe, active-low
//     dout     status byte returned by the raster block
//     dout_en  status byte is being read this cycle
//
//   Modports
//     master   CPU side: drives the strobes and data, receives the status
//     slave    raster block side
// ----------------------------------------------------------------------------
interface video_raster_irq_if;
  logic [15:0] addr;
  logic [7:0]  din;
  logic        nIORQ;
  logic        nWR;
  logic [7:0]  dout;
  logic        dout_en;

  modport master (output addr, din, nIORQ, nWR, input dout, dout_en);
  modport slave  (input addr, din, nIORQ, nWR, output dout, dout_en);
endinterface

// File: rtl/video_raster_irq.sv
// ----------------------------------------------------------------------------
// video_raster_irq
//   Raster timing generator (H/V counters, blank/sync strobes, paper window,
//   flash phase) with INT_CH programmable line-interrupt channels and a frame
//   interrupt. Pending flags are sticky until acknowledged by the CPU or until
//   the counter reaches hc == INT_LEN on the same line.
//
//   Ports
//     clk_sys   master clock
//     reset     synchronous, active-high
//     ce_pix    pixel clock enable; every piece of state advances only on it
//     bus       CPU I/O bus (slave modport): compare writes, ack, status read
//     hc, vc    horizontal / vertical counters
//     HBlank, HSync, VBlank, VSync   registered timing strobes (1-ce lag)
//     paper     registered active-display window
//     flash     bit 4 of the frame counter
//     INT_line  OR of all line-interrupt pending flags
//     INT_frame frame-interrupt pending flag
// ----------------------------------------------------------------------------
module video_raster_irq #(
  parameter int unsigned H_TOTAL   = 384,
  parameter int unsigned V_TOTAL   = 312,
  parameter int unsigned HB_START  = 24,
  parameter int unsigned HS_START  = 40,
  parameter int unsigned HS_END    = 72,
  parameter int unsigned HB_END    = 104,
  parameter int unsigned VB_START  = 240,
  parameter int unsigned VS_START  = 244,
  parameter int unsigned VS_END    = 248,
  parameter int unsigned VB_END    = 264,
  parameter int unsigned PAPER_H   = 128,
  parameter int unsigned PAPER_V   = 192,
  parameter int unsigned INT_LEN   = 128,
  parameter int unsigned INT_CH    = 2,
  parameter int unsigned INTL_PORT = 249
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 ce_pix,
  video_raster_irq_if.slave    bus,
  output logic [8:0]           hc,
  output logic [8:0]           vc,
  output logic                 HBlank,
  output logic                 HSync,
  output logic                 VBlank,
  output logic                 VSync,
  output logic                 paper,
  output logic                 flash,
  output logic                 INT_line,
  output logic                 INT_frame
);

  localparam logic [8:0] HC_LAST  = 9'(H_TOTAL - 1);
  localparam logic [8:0] VC_LAST  = 9'(V_TOTAL - 1);
  localparam logic [8:0] HB_SET   = 9'(HB_START);
  localparam logic [8:0] HB_CLR   = 9'(HB_END);
  localparam logic [8:0] HS_SET   = 9'(HS_START);
  localparam logic [8:0] HS_CLR   = 9'(HS_END);
  localparam logic [8:0] VB_SET   = 9'(VB_START);
  localparam logic [8:0] VB_CLR   = 9'(VB_END);
  localparam logic [8:0] VS_SET   = 9'(VS_START);
  localparam logic [8:0] VS_CLR   = 9'(VS_END);
  localparam logic [8:0] PAPER_HC = 9'(PAPER_H);
  localparam logic [8:0] PAPER_VC = 9'(PAPER_V);
  localparam logic [8:0] INT_END  = 9'(INT_LEN);
  localparam logic [7:0] PORT_CMP = 8'(INTL_PORT);
  localparam logic [7:0] PORT_ACK = 8'(INTL_PORT + 1);

  logic [8:0]        hc_q, hc_d;
  logic [8:0]        vc_q, vc_d;
  logic [4:0]        frame_cnt_q, frame_cnt_d;
  logic              hblank_q, hblank_d;
  logic              hsync_q, hsync_d;
  logic              vblank_q, vblank_d;
  logic              vsync_q, vsync_d;
  logic              paper_q, paper_d;
  logic              wr_q, wr_d;
  logic [7:0]        cmp_q [INT_CH];
  logic [7:0]        cmp_d [INT_CH];
  logic [INT_CH-1:0] line_pend_q, line_pend_d;
  logic              frame_pend_q, frame_pend_d;

  logic              wr_now;
  logic [INT_CH-1:0] line_set, line_clr;
  logic              frame_set, frame_clr;
  logic              unused_addr;

  assign unused_addr = ^bus.addr[15:10];

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    wr_now       = ~bus.nIORQ & ~bus.nWR;
    hc_d         = hc_q;
    vc_d         = vc_q;
    frame_cnt_d  = frame_cnt_q;
    hblank_d     = hblank_q;
    hsync_d      = hsync_q;
    vblank_d     = vblank_q;
    vsync_d      = vsync_q;
    paper_d      = paper_q;
    wr_d         = wr_q;
    cmp_d        = cmp_q;
    line_set     = '0;
    line_clr     = '0;
    frame_set    = 1'b0;
    frame_clr    = 1'b0;
    line_pend_d  = line_pend_q;
    frame_pend_d = frame_pend_q;

    if (ce_pix) begin
      wr_d = wr_now;

      if (hc_q == HC_LAST) begin
        hc_d = '0;
        if (vc_q == VC_LAST) begin
          vc_d        = '0;
          frame_cnt_d = frame_cnt_q + 5'd1;
        end else begin
          vc_d = vc_q + 9'd1;
        end
      end else begin
        hc_d = hc_q + 9'd1;
      end

      // Clear is tested first so equal start/end parameters keep a strobe low.
      if (hc_q == HB_CLR)      hblank_d = 1'b0;
      else if (hc_q == HB_SET) hblank_d = 1'b1;

      if (hc_q == HS_CLR)      hsync_d = 1'b0;
      else if (hc_q == HS_SET) hsync_d = 1'b1;

      if (vc_q == VB_CLR && hc_q == HB_CLR)      vblank_d = 1'b0;
      else if (vc_q == VB_SET && hc_q == HB_SET) vblank_d = 1'b1;

      if (vc_q == VS_CLR && hc_q == '0)      vsync_d = 1'b0;
      else if (vc_q == VS_SET && hc_q == '0) vsync_d = 1'b1;

      paper_d = (hc_q >= PAPER_HC) && (vc_q < PAPER_VC);

      if (hc_q == INT_END) begin
        line_clr  = '1;
        frame_clr = 1'b1;
      end

      // Only the first ce of a bus cycle acts; a held strobe is ignored.
      if (wr_now && !wr_q) begin
        if (bus.addr[7:0] == PORT_CMP) begin
          for (int i = 0; i < int'(INT_CH); i++) begin
            if (bus.addr[9:8] == 2'(i)) cmp_d[i] = bus.din;
          end
        end
        if (bus.addr[7:0] == PORT_ACK) begin
          line_clr  = line_clr | bus.din[INT_CH-1:0];
          frame_clr = frame_clr | bus.din[7];
        end
      end

      // Compares at or beyond the paper height act as "disabled".
      for (int i = 0; i < int'(INT_CH); i++) begin
        line_set[i] = (hc_q == '0) && (vc_q == {1'b0, cmp_q[i]}) &&
                      ({1'b0, cmp_q[i]} < PAPER_VC);
      end
      frame_set = (hc_q == '0) && (vc_q == VS_SET);

      // A new event outranks an acknowledge or auto-clear on the same ce.
      line_pend_d  = (line_pend_q & ~line_clr) | line_set;
      frame_pend_d = (frame_pend_q & ~frame_clr) | frame_set;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hc_q         <= '0;
      vc_q         <= '0;
      frame_cnt_q  <= '0;
      hblank_q     <= 1'b0;
      hsync_q      <= 1'b0;
      vblank_q     <= 1'b0;
      vsync_q      <= 1'b0;
      paper_q      <= 1'b0;
      // Tracking the bus during reset swallows a write already in flight.
      wr_q         <= wr_now;
      // NOTE: the compare array is small and must read back as disabled
      // after reset, so it is reset like ordinary flops rather than left
      // uninitialised as a RAM would be.
      cmp_q        <= '{default: 8'hFF};
      line_pend_q  <= '0;
      frame_pend_q <= 1'b0;
    end else begin
      hc_q         <= hc_d;
      vc_q         <= vc_d;
      frame_cnt_q  <= frame_cnt_d;
      hblank_q     <= hblank_d;
      hsync_q      <= hsync_d;
      vblank_q     <= vblank_d;
      vsync_q      <= vsync_d;
      paper_q      <= paper_d;
      wr_q         <= wr_d;
      cmp_q        <= cmp_d;
      line_pend_q  <= line_pend_d;
      frame_pend_q <= frame_pend_d;
    end
  end

  // Status byte is active-low: a 0 bit means the matching flag is pending.
  always_comb begin
    bus.dout = 8'hFF;
    for (int i = 0; i < int'(INT_CH); i++) begin
      bus.dout[i] = ~line_pend_q[i];
    end
    bus.dout[7] = ~frame_pend_q;
  end

  assign bus.dout_en = ~bus.nIORQ & bus.nWR & (bus.addr[7:0] == PORT_CMP);

  assign hc        = hc_q;
  assign vc        = vc_q;
  assign HBlank    = hblank_q;
  assign HSync     = hsync_q;
  assign VBlank    = vblank_q;
  assign VSync     = vsync_q;
  assign paper     = paper_q;
  assign flash     = frame_cnt_q[4];
  assign INT_line  = |line_pend_q;
  assign INT_frame = frame_pend_q;

endmodule

// File: tb/tb_video_raster_irq.sv
// ----------------------------------------------------------------------------
// tb_video_raster_irq
//   Directed bench for video_raster_irq using a shrunken raster (48 x 40) so
//   many frames fit in a short run. A tiny counter model tracks hc/vc/frame
//   position so each step can be placed on an exact ce; all other expected
//   values are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_video_raster_irq;

  localparam int H_T   = 48;
  localparam int V_T   = 40;
  localparam int LIMIT = 40000;

  logic       clk_sys;
  logic       reset;
  logic       ce_pix;
  logic [8:0] hc, vc;
  logic       HBlank, HSync, VBlank, VSync, paper, flash, INT_line, INT_frame;
  logic [7:0] strb;

  int n_cmp = 0;
  int n_err = 0;
  int m_hc  = 0;
  int m_vc  = 0;
  int m_frame = 0;

  video_raster_irq_if bus_if ();

  video_raster_irq #(
    .H_TOTAL(48), .V_TOTAL(40),
    .HB_START(4), .HS_START(6), .HS_END(10), .HB_END(14),
    .VB_START(30), .VS_START(32), .VS_END(34), .VB_END(36),
    .PAPER_H(16), .PAPER_V(24), .INT_LEN(20), .INT_CH(2), .INTL_PORT(249)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .ce_pix    (ce_pix),
    .bus       (bus_if.slave),
    .hc        (hc),
    .vc        (vc),
    .HBlank    (HBlank),
    .HSync     (HSync),
    .VBlank    (VBlank),
    .VSync     (VSync),
    .paper     (paper),
    .flash     (flash),
    .INT_line  (INT_line),
    .INT_frame (INT_frame)
  );

  assign strb = {HBlank, HSync, VBlank, VSync, paper, flash, INT_line, INT_frame};

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_sys);
    #1;
    if (reset) begin
      m_hc = 0; m_vc = 0; m_frame = 0;
    end else if (ce_pix) begin
      if (m_hc == H_T - 1) begin
        m_hc = 0;
        if (m_vc == V_T - 1) begin
          m_vc = 0;
          m_frame = (m_frame + 1) % 32;
        end else begin
          m_vc++;
        end
      end else begin
        m_hc++;
      end
    end
  endtask

  task automatic goto_pos(input int v, input int h);
    int  n = 0;
    logic reached;
    while (!(m_vc == v && m_hc == h) && n < LIMIT) begin
      tick();
      n++;
    end
    reached = (m_vc == v && m_hc == h);
    n_cmp++;
    assert (reached) else begin
      n_err++;
      $error("FAIL goto: position %0d/%0d not reached, stuck at %0d/%0d", v, h, m_vc, m_hc);
    end
  endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] d);
    bus_if.addr  = a;
    bus_if.din   = d;
    bus_if.nIORQ = 1'b0;
    bus_if.nWR   = 1'b0;
    tick();
    bus_if.nIORQ = 1'b1;
    bus_if.nWR   = 1'b1;
    tick();
  endtask

  task automatic rd_status(input string tag, input logic [7:0] exp);
    bus_if.addr  = 16'h00F9;
    bus_if.nIORQ = 1'b0;
    bus_if.nWR   = 1'b1;
    #1;
    chk(tag, bus_if.dout, exp);
    chk({tag, "_en"}, bus_if.dout_en, 1'b1);
    bus_if.nIORQ = 1'b1;
    #1;
  endtask

  task automatic scan_frame(input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < H_T * V_T; i++) begin
      tick();
      seen = seen | INT_line;
    end
    chk(tag, seen, 1'b0);
  endtask

  initial begin
    reset        = 1'b1;
    ce_pix       = 1'b1;
    bus_if.addr  = 16'h0000;
    bus_if.din   = 8'h00;
    bus_if.nIORQ = 1'b1;
    bus_if.nWR   = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    chk("rst_hc", hc, 9'd0);
    chk("rst_vc", vc, 9'd0);
    chk("rst_strobes", strb, 8'h00);
    chk("idle_dout_en", bus_if.dout_en, 1'b0);
    rd_status("rst_status", 8'hFF);

    // Counter wrap
    goto_pos(0, 47);
    chk("hc_last", hc, 9'd47);
    tick();
    chk("hc_wrap", hc, 9'd0);
    chk("vc_step", vc, 9'd1);

    // Horizontal strobes and paper (one-ce lag)
    goto_pos(1, 4);  chk("hblank_pre", HBlank, 1'b0);
    tick();          chk("hblank_rise", HBlank, 1'b1);
    goto_pos(1, 6);  chk("hsync_pre", HSync, 1'b0);
    tick();          chk("hsync_rise", HSync, 1'b1);
    goto_pos(1, 10); chk("hsync_last", HSync, 1'b1);
    tick();          chk("hsync_fall", HSync, 1'b0);
    goto_pos(1, 14); chk("hblank_last", HBlank, 1'b1);
    tick();          chk("hblank_fall", HBlank, 1'b0);
    goto_pos(1, 16); chk("paper_pre", paper, 1'b0);
    tick();          chk("paper_rise", paper, 1'b1);
    goto_pos(24, 0); chk("paper_lastline", paper, 1'b1);
    tick();          chk("paper_off", paper, 1'b0);

    // Vertical strobes and frame interrupt
    goto_pos(30, 4);  chk("vblank_pre", VBlank, 1'b0);
    tick();           chk("vblank_rise", VBlank, 1'b1);
    goto_pos(32, 0);  chk("vsync_pre", VSync, 1'b0);
    chk("intf_pre", INT_frame, 1'b0);
    tick();           chk("vsync_rise", VSync, 1'b1);
    chk("intf_rise", INT_frame, 1'b1);
    goto_pos(32, 20); chk("intf_hold", INT_frame, 1'b1);
    tick();           chk("intf_autoclr", INT_frame, 1'b0);
    goto_pos(34, 0);  chk("vsync_last", VSync, 1'b1);
    tick();           chk("vsync_fall", VSync, 1'b0);
    goto_pos(36, 14); chk("vblank_last", VBlank, 1'b1);
    tick();           chk("vblank_fall", VBlank, 1'b0);
    goto_pos(39, 47);
    tick();
    chk("vc_wrap", vc, 9'd0);
    chk("vc_wrap_hc", hc, 9'd0);

    // Single line interrupt on channel 0
    io_write(16'h00F9, 8'd5);
    goto_pos(5, 0);  chk("l5_pre", INT_line, 1'b0);
    rd_status("l5_pre_st", 8'hFF);
    tick();          chk("l5_rise", INT_line, 1'b1);
    rd_status("l5_st", 8'hFE);
    goto_pos(5, 20); chk("l5_hold", INT_line, 1'b1);
    tick();          chk("l5_autoclr", INT_line, 1'b0);
    rd_status("l5_clr_st", 8'hFF);

    // Two channels on the same line, acknowledged one at a time
    io_write(16'h01F9, 8'd5);
    goto_pos(5, 1);  rd_status("dual_st", 8'hFC);
    chk("dual_int", INT_line, 1'b1);
    goto_pos(5, 10);
    io_write(16'h00FA, 8'h01);
    rd_status("ack0_st", 8'hFD);
    chk("ack0_int", INT_line, 1'b1);
    io_write(16'h00FA, 8'h02);
    rd_status("ack1_st", 8'hFF);
    chk("ack1_int", INT_line, 1'b0);

    // Compare boundary: PAPER_V-1 fires, PAPER_V does not
    io_write(16'h00F9, 8'd24);
    io_write(16'h01F9, 8'd23);
    goto_pos(23, 0); chk("l23_pre", INT_line, 1'b0);
    tick();          rd_status("l23_st", 8'hFD);
    chk("l23_int", INT_line, 1'b1);
    goto_pos(24, 1); chk("l24_nofire", INT_line, 1'b0);

    // Disabled compares and out-of-range channels: silent for a full frame
    io_write(16'h01F9, 8'd30);
    io_write(16'h03F9, 8'd5);
    io_write(16'h02F9, 8'd5);
    scan_frame("no_line_frame");

    // Compare rewritten to the current line after hc==0
    goto_pos(10, 5);
    io_write(16'h00F9, 8'd10);
    chk("rewr_now", INT_line, 1'b0);
    goto_pos(10, 30); chk("rewr_line", INT_line, 1'b0);
    goto_pos(10, 1);  chk("rewr_next", INT_line, 1'b1);
    rd_status("rewr_st", 8'hFE);

    // Ack on the same ce as the frame set: the set wins
    goto_pos(32, 0);
    io_write(16'h00FA, 8'h80);
    chk("ackf_race", INT_frame, 1'b1);
    rd_status("ackf_race_st", 8'h7F);
    io_write(16'h00FA, 8'h80);
    chk("ackf_clr", INT_frame, 1'b0);
    rd_status("ackf_clr_st", 8'hFF);

    // Mid-frame reset with a pending interrupt and a write in flight
    io_write(16'h00F9, 8'd15);
    goto_pos(15, 3); chk("prerst_int", INT_line, 1'b1);
    bus_if.addr  = 16'h00F9;
    bus_if.din   = 8'd7;
    bus_if.nIORQ = 1'b0;
    bus_if.nWR   = 1'b0;
    reset        = 1'b1;
    tick();
    chk("mrst_hc", hc, 9'd0);
    chk("mrst_vc", vc, 9'd0);
    chk("mrst_strobes", strb, 8'h00);
    reset = 1'b0;
    tick();
    chk("mrst_hc_run", hc, 9'd1);
    bus_if.nIORQ = 1'b1;
    bus_if.nWR   = 1'b1;
    tick();
    rd_status("mrst_st", 8'hFF);
    scan_frame("mrst_no_line");

    // ce_pix low freezes the counters
    ce_pix = 1'b0;
    repeat (5) tick();
    chk("ce_hold_hc", hc, 9'(m_hc));
    chk("ce_hold_vc", vc, 9'(m_vc));
    ce_pix = 1'b1;
    tick();
    chk("ce_resume_hc", hc, 9'(m_hc));

    // Flash phase toggles after 16 frames
    begin
      int n = 0;
      while (m_frame != 15 && n < LIMIT) begin tick(); n++; end
      chk("flash_f15", flash, 1'b0);
      n = 0;
      while (m_frame != 16 && n < LIMIT) begin tick(); n++; end
      chk("flash_f16", flash, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
